// File: rtl/mbist_pkg.sv
// mbist_pkg: shared pattern codes, FSM state encoding and the element descriptor
// used by the MBIST sequencer and its element lookup table.
package mbist_pkg;

    localparam logic [2:0] PAT_MSCAN  = 3'd0;
    localparam logic [2:0] PAT_CHKB   = 3'd1;
    localparam logic [2:0] PAT_MARCHC = 3'd2;

    localparam logic [2:0] ELEMS_MSCAN  = 3'd4;
    localparam logic [2:0] ELEMS_CHKB   = 3'd4;
    localparam logic [2:0] ELEMS_MARCHC = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_W  = 2'd0,
        OP_R  = 2'd1,
        OP_RW = 2'd2
    } op_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef struct packed {
        logic [3:0] turn;
        op_e        op;
        dir_e       dir;
        logic       last;
    } elem_t;

    function automatic logic [2:0] elem_count(input logic [2:0] pat);
        case (pat)
            PAT_MSCAN:  return ELEMS_MSCAN;
            PAT_CHKB:   return ELEMS_CHKB;
            PAT_MARCHC: return ELEMS_MARCHC;
            default:    return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mbist_ctrl_if.sv
// mbist_ctrl_if: generator and SRAM port bundle driven by the MBIST sequencer.
interface mbist_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [2:0]        PAT_SEL;
    logic [3:0]        GEN_TURN;
    logic              DATA_EN;
    logic [DATA_W-1:0] EXP_DATA;
    logic [ADDR_W-1:0] ADDR;
    logic              CS;
    logic              WE;
    logic [DATA_W-1:0] RDATA;

    // CS=1 marks an SRAM access in that cycle (WE=1 write, WE=0 read); read data
    // returns on RDATA the following cycle. DATA_EN is a one-cycle strobe that
    // makes the generator take GEN_TURN for the next element.
    modport master (
        output PAT_SEL, GEN_TURN, DATA_EN, ADDR, CS, WE,
        input  EXP_DATA, RDATA
    );

    modport slave (
        input  PAT_SEL, GEN_TURN, DATA_EN, ADDR, CS, WE,
        output EXP_DATA, RDATA
    );

endinterface

// File: rtl/mbist_elem_table.sv
// mbist_elem_table: combinational map from (pattern, element index) to the
// element descriptor (generator turn, operation, sweep direction, last flag).
module mbist_elem_table
    import mbist_pkg::*;
(
    input  logic [2:0] pat_i,
    input  logic [2:0] idx_i,
    output elem_t      elem_o
);

    always_comb begin
        elem_o.turn = 4'd0;
        elem_o.op   = OP_W;
        elem_o.dir  = DIR_UP;
        case (pat_i)
            PAT_MSCAN: begin
                elem_o.turn = idx_i[1] ? 4'd3 : 4'd1;
                elem_o.op   = idx_i[0] ? OP_R : OP_W;
            end
            PAT_CHKB: begin
                elem_o.turn = idx_i[1] ? 4'hF : 4'h0;
                elem_o.op   = idx_i[0] ? OP_R : OP_W;
            end
            PAT_MARCHC: begin
                elem_o.turn = {1'b0, idx_i};
                elem_o.op   = (idx_i == 3'd0) ? OP_W : (idx_i == 3'd5) ? OP_R : OP_RW;
                elem_o.dir  = (idx_i == 3'd3 || idx_i == 3'd4) ? DIR_DOWN : DIR_UP;
            end
            default: ;
        endcase
        elem_o.last = (idx_i == elem_count(pat_i) - 3'd1);
    end

endmodule

// File: rtl/mbist_ctrl.sv
// mbist_ctrl: MBIST sequencer running MSCAN, checkerboard and March C- over the SRAM.
// Define MBIST_FAIL_LOG_EN to log the first failing address and a mismatch count.
module mbist_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [2:0]        MODE,
    mbist_ctrl_if.master      bus,
    output logic              BUSY,
    output logic              DONE,
    output logic              FAIL,
    output logic [ADDR_W-1:0] FAIL_ADDR,
    output logic [7:0]        FAIL_CNT,
    output state_e            DBG_STATE
);

    state_e            state_q, state_d;
    logic [2:0]        pat_q, pat_d;
    logic [2:0]        elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              fail_q, fail_d;
`ifdef MBIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [7:0]        fail_cnt_q, fail_cnt_d;
`endif

    logic [ADDR_W-1:0] start_addr;
    logic              start_ok, last_addr, rd_cycle, mismatch;
    elem_t             cur;

    mbist_elem_table u_table (
        .pat_i  (pat_q),
        .idx_i  (elem_q),
        .elem_o (cur)
    );

    assign start_ok   = START && (MODE <= PAT_MARCHC) &&
                        (state_q == ST_IDLE || state_q == ST_DONE);
    assign start_addr = (cur.dir == DIR_DOWN) ? '1 : '0;
    assign last_addr  = (cur.dir == DIR_DOWN) ? (addr_q == '0) : (addr_q == '1);
    // In a read-then-write element phase 0 is the read, phase 1 the write.
    assign rd_cycle   = (state_q == ST_RUN) &&
                        (cur.op == OP_R || (cur.op == OP_RW && !phase_q));
    assign mismatch   = vld_q && (bus.RDATA != exp_q);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            elem_q      <= '0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            vld_q       <= 1'b0;
            exp_q       <= '0;
            fail_q      <= 1'b0;
`ifdef MBIST_FAIL_LOG_EN
            cmp_addr_q  <= '0;
            fail_addr_q <= '0;
            fail_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            vld_q       <= vld_d;
            exp_q       <= exp_d;
            fail_q      <= fail_d;
`ifdef MBIST_FAIL_LOG_EN
            cmp_addr_q  <= cmp_addr_d;
            fail_addr_q <= fail_addr_d;
            fail_cnt_q  <= fail_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        // Expected data is captured at read issue so a following LOAD cannot disturb it.
        vld_d   = rd_cycle;
        exp_d   = rd_cycle ? bus.EXP_DATA : exp_q;
        fail_d  = fail_q;
`ifdef MBIST_FAIL_LOG_EN
        cmp_addr_d  = rd_cycle ? addr_q : cmp_addr_q;
        fail_addr_d = fail_addr_q;
        fail_cnt_d  = fail_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_LOAD;
                    pat_d   = MODE;
                    elem_d  = '0;
                    phase_d = 1'b0;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                addr_d  = start_addr;
                phase_d = 1'b0;
            end
            ST_RUN: begin
                if (cur.op == OP_RW && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!last_addr) begin
                        addr_d = (cur.dir == DIR_DOWN) ? addr_q - 1'b1 : addr_q + 1'b1;
                    end else if (cur.last) begin
                        state_d = ST_DRAIN;
                    end else begin
                        elem_d  = elem_q + 3'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase

        if (start_ok) begin
            fail_d = 1'b0;
`ifdef MBIST_FAIL_LOG_EN
            fail_addr_d = '0;
            fail_cnt_d  = '0;
`endif
        end else if (mismatch) begin
            fail_d = 1'b1;
`ifdef MBIST_FAIL_LOG_EN
            if (!fail_q) fail_addr_d = cmp_addr_q;
            if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
`endif
        end
    end

    always_comb begin
        bus.PAT_SEL  = pat_q;
        bus.GEN_TURN = '0;
        bus.DATA_EN  = 1'b0;
        bus.ADDR     = addr_q;
        bus.CS       = 1'b0;
        bus.WE       = 1'b0;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        FAIL         = fail_q;
        DBG_STATE    = state_q;
`ifdef MBIST_FAIL_LOG_EN
        FAIL_ADDR    = fail_addr_q;
        FAIL_CNT     = fail_cnt_q;
`else
        FAIL_ADDR    = '0;
        FAIL_CNT     = '0;
`endif
        unique case (state_q)
            ST_LOAD: begin
                bus.GEN_TURN = cur.turn;
                bus.DATA_EN  = 1'b1;
                bus.ADDR     = start_addr;
                BUSY         = 1'b1;
            end
            ST_RUN: begin
                bus.GEN_TURN = cur.turn;
                bus.CS       = 1'b1;
                bus.WE       = !rd_cycle;
                BUSY         = 1'b1;
            end
            ST_DRAIN: BUSY = 1'b1;
            ST_DONE:  DONE = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mbist_ctrl.sv
// tb_mbist_ctrl: bench with data generator and faulty-SRAM models, a vector table,
// hand-written reset/unsupported-mode sequences and randomized runs.
`timescale 1ns/1ps
module tb_mbist_ctrl;
    import mbist_pkg::*;

    typedef struct {
        logic [2:0]  mode;
        logic        flt_en;
        logic [3:0]  flt_addr;
        logic [7:0]  flt_mask;
        logic [7:0]  flt_val;
        int          exp_busy;
        int          exp_den;
        logic [23:0] exp_turns;
        logic        exp_fail;
        logic [3:0]  exp_faddr;
        int          exp_fcnt;
    } vec_t;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [2:0] MODE;
    logic       BUSY, DONE, FAIL;
    logic [3:0] FAIL_ADDR;
    logic [7:0] FAIL_CNT;
    state_e     dbg_state;

    logic       flt_en;
    logic [3:0] flt_addr;
    logic [7:0] flt_mask, flt_val;
    logic [3:0] gen_turn_q;
    logic [7:0] mem [16];
    logic [7:0] rdata_q;

    int checks;
    int errors;
    vec_t vecs[6];

    mbist_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    mbist_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .MODE      (MODE),
        .bus       (bus),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .FAIL      (FAIL),
        .FAIL_ADDR (FAIL_ADDR),
        .FAIL_CNT  (FAIL_CNT),
        .DBG_STATE (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- generator and SRAM models ----------------
    function automatic logic [7:0] gen_fn(input logic [2:0] p, input logic [3:0] t,
                                          input logic [3:0] a, input logic wr);
        logic [7:0] cb;
        cb = a[0] ? 8'h55 : 8'hAA;
        case (p)
            3'd0:    return (t == 4'd3) ? 8'hFF : 8'h00;
            3'd1:    return (t == 4'hF) ? ~cb : cb;
            default: begin
                if (wr) return (t == 4'd1 || t == 4'd3) ? 8'hFF : 8'h00;
                else    return (t == 4'd2 || t == 4'd4) ? 8'hFF : 8'h00;
            end
        endcase
    endfunction

    function automatic logic [7:0] faulty(input logic [7:0] d, input logic [3:0] a,
                                          input logic en, input logic [3:0] fa,
                                          input logic [7:0] m, input logic [7:0] v);
        if (en && a == fa) return (d & ~m) | (v & m);
        return d;
    endfunction

    always @(posedge CLK) begin
        if (bus.DATA_EN) gen_turn_q <= bus.GEN_TURN;
        if (bus.CS && bus.WE) mem[bus.ADDR] <= gen_fn(bus.PAT_SEL, gen_turn_q, bus.ADDR, 1'b1);
        if (bus.CS && !bus.WE)
            rdata_q <= faulty(mem[bus.ADDR], bus.ADDR, flt_en, flt_addr, flt_mask, flt_val);
    end

    assign bus.EXP_DATA = gen_fn(bus.PAT_SEL, gen_turn_q, bus.ADDR, 1'b0);
    assign bus.RDATA    = rdata_q;

    // ---------------- reference model: algorithm walk over an array ----------------
    function automatic vec_t ref_fill(input vec_t v);
        int n;
        int tn[6];
        int op[6];
        bit dn[6];
        logic [7:0] m [16];
        logic [7:0] rd;
        int a;
        vec_t r;
        r = v;
        for (int i = 0; i < 16; i++) m[i] = 8'h00;
        for (int i = 0; i < 6; i++) dn[i] = 1'b0;
        case (v.mode)
            3'd0:    begin n = 4; tn = '{1, 1, 3, 3, 0, 0};   op = '{0, 1, 0, 1, 0, 0}; end
            3'd1:    begin n = 4; tn = '{0, 0, 15, 15, 0, 0}; op = '{0, 1, 0, 1, 0, 0}; end
            default: begin n = 6; tn = '{0, 1, 2, 3, 4, 5};   op = '{0, 2, 2, 2, 2, 1};
                           dn[3] = 1'b1; dn[4] = 1'b1; end
        endcase
        r.exp_busy = 1;
        r.exp_den = n;
        r.exp_turns = '0;
        r.exp_fail = 1'b0;
        r.exp_faddr = '0;
        r.exp_fcnt = 0;
        for (int e = 0; e < n; e++) begin
            r.exp_turns = {r.exp_turns[19:0], 4'(tn[e])};
            r.exp_busy += 1;
            for (int k = 0; k < 16; k++) begin
                a = dn[e] ? 15 - k : k;
                if (op[e] != 0) begin
                    r.exp_busy += 1;
                    rd = faulty(m[a], 4'(a), v.flt_en, v.flt_addr, v.flt_mask, v.flt_val);
                    if (rd != gen_fn(v.mode, 4'(tn[e]), 4'(a), 1'b0)) begin
                        if (!r.exp_fail) r.exp_faddr = 4'(a);
                        r.exp_fail = 1'b1;
                        if (r.exp_fcnt < 255) r.exp_fcnt++;
                    end
                end
                if (op[e] != 1) begin
                    r.exp_busy += 1;
                    m[a] = gen_fn(v.mode, 4'(tn[e]), 4'(a), 1'b1);
                end
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_outputs"}, {bus.PAT_SEL, bus.GEN_TURN, bus.DATA_EN, bus.ADDR, bus.CS,
                                bus.WE, BUSY, DONE, FAIL, FAIL_ADDR, FAIL_CNT}, 32'd0);
        chk({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    function automatic vec_t mk(input logic [2:0] mode, input logic en, input logic [3:0] fa,
                                input logic [7:0] fm, input logic [7:0] fv, input int busy,
                                input int den, input logic [23:0] turns, input logic fail,
                                input logic [3:0] faddr, input int fcnt);
        vec_t v;
        v.mode = mode; v.flt_en = en; v.flt_addr = fa; v.flt_mask = fm; v.flt_val = fv;
        v.exp_busy = busy; v.exp_den = den; v.exp_turns = turns;
        v.exp_fail = fail; v.exp_faddr = faddr; v.exp_fcnt = fcnt;
        return v;
    endfunction

    // ---------------- driver: one complete run ----------------
    task automatic run_vec(input vec_t v, input string tag);
        int busy, den, cyc, e;
        logic [23:0] turns;
        int first_a[6];
        int last_a[6];
        for (int i = 0; i < 6; i++) begin first_a[i] = -1; last_a[i] = -1; end
        flt_en = v.flt_en; flt_addr = v.flt_addr; flt_mask = v.flt_mask; flt_val = v.flt_val;
        @(negedge CLK);
        START = 1'b1;
        MODE  = v.mode;
        @(negedge CLK);
        START = 1'b0;
        chk({tag, "_pat_sel"}, bus.PAT_SEL, v.mode);
        busy = 0; den = 0; cyc = 0; e = -1; turns = '0;
        while (!DONE && cyc < 400) begin
            if (BUSY) busy++;
            if (bus.DATA_EN) begin
                den++;
                turns = {turns[19:0], bus.GEN_TURN};
                if (e < 5) e++;
            end
            if (bus.CS && e >= 0) begin
                if (first_a[e] < 0) first_a[e] = int'(bus.ADDR);
                last_a[e] = int'(bus.ADDR);
            end
            @(negedge CLK);
            cyc++;
        end
        chk({tag, "_done"}, DONE, 1'b1);
        chk({tag, "_busy_cycles"}, busy, v.exp_busy);
        chk({tag, "_data_en_pulses"}, den, v.exp_den);
        chk({tag, "_turns"}, turns, v.exp_turns);
        chk({tag, "_fail"}, FAIL, v.exp_fail);
`ifdef MBIST_FAIL_LOG_EN
        chk({tag, "_fail_addr"}, FAIL_ADDR, v.exp_faddr);
        chk({tag, "_fail_cnt"}, FAIL_CNT, v.exp_fcnt);
`else
        chk({tag, "_fail_addr"}, FAIL_ADDR, 32'd0);
        chk({tag, "_fail_cnt"}, FAIL_CNT, 32'd0);
`endif
        chk({tag, "_e0_sweep"}, {first_a[0][7:0], last_a[0][7:0]}, {8'd0, 8'd15});
        if (v.mode == 3'd2) begin
            chk({tag, "_e1_sweep"}, {first_a[1][7:0], last_a[1][7:0]}, {8'd0, 8'd15});
            chk({tag, "_e3_sweep"}, {first_a[3][7:0], last_a[3][7:0]}, {8'd15, 8'd0});
            chk({tag, "_e4_sweep"}, {first_a[4][7:0], last_a[4][7:0]}, {8'd15, 8'd0});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        checks = 0;
        errors = 0;
        RESET = 1'b1;
        START = 1'b0;
        MODE = 3'd0;
        flt_en = 1'b0; flt_addr = '0; flt_mask = '0; flt_val = '0;

        //       mode   en    addr   mask   val    busy den turns     fail faddr cnt
        vecs[0] = mk(3'd0, 1'b0, 4'd0,  8'h00, 8'h00, 69,  4, 24'h001133, 1'b0, 4'd0,  0);
        vecs[1] = mk(3'd2, 1'b0, 4'd0,  8'h00, 8'h00, 167, 6, 24'h012345, 1'b0, 4'd0,  0);
        vecs[2] = mk(3'd2, 1'b1, 4'd5,  8'h01, 8'h01, 167, 6, 24'h012345, 1'b1, 4'd5,  3);
        vecs[3] = mk(3'd1, 1'b1, 4'd15, 8'hFF, 8'h55, 69,  4, 24'h0000FF, 1'b1, 4'd15, 1);
        vecs[4] = mk(3'd1, 1'b0, 4'd0,  8'h00, 8'h00, 69,  4, 24'h0000FF, 1'b0, 4'd0,  0);
        vecs[5] = mk(3'd0, 1'b1, 4'd0,  8'h80, 8'h00, 69,  4, 24'h001133, 1'b1, 4'd0,  1);

        repeat (3) @(negedge CLK);
        chk_reset_outputs("reset");
        RESET = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset at cycle 40 of a March C- run, then a clean MSCAN run.
        @(negedge CLK);
        START = 1'b1;
        MODE  = 3'd2;
        @(negedge CLK);
        START = 1'b0;
        repeat (39) @(negedge CLK);
        #2 RESET = 1'b1;
        #1 chk_reset_outputs("midrun_reset");
        @(negedge CLK);
        RESET = 1'b0;
        run_vec(vecs[0], "after_reset");

        // Unsupported mode from IDLE must be ignored.
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        START = 1'b1;
        MODE  = 3'd5;
        bad = 0;
        repeat (8) begin
            @(negedge CLK);
            if (BUSY || bus.DATA_EN || DONE) bad++;
        end
        START = 1'b0;
        chk("bad_mode_activity", bad, 32'd0);
        chk("bad_mode_state", dbg_state, ST_IDLE);

        for (int i = 0; i < 10; i++) begin
            vec_t v;
            v.mode     = 3'($urandom_range(0, 2));
            v.flt_en   = 1'($urandom_range(0, 1));
            v.flt_addr = 4'($urandom_range(0, 15));
            v.flt_mask = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'(1 << $urandom_range(0, 7));
            v.flt_val  = 8'($urandom);
            v = ref_fill(v);
            run_vec(v, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbist_ctrl.md
# mbist_ctrl

Sequencer for the MBIST datapath. It steps the pattern/data generator through its `PAT_SEL`/`gen_Turn` codes and issues the `DATA_EN` load strobe. It also drives SRAM address and read/write control and compares read data against the generator's expected value. It sits between the test-mode top level (`START`/`MODE`) and the data generator plus SRAM under test, and reports `DONE`/`FAIL`.

## Interface
- `ADDR_W`, default 4: SRAM address width; N = 2^ADDR_W words.
- `DATA_W`, default 8: SRAM/generator data width.
- `CLK`  in  1  single clock, rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `START`  in  1  level, sampled in IDLE/DONE; starts a run.
- `MODE`  in  3  test select: 0 MSCAN, 1 checkerboard, 2 March C-; others unsupported.
- `PAT_SEL`  out  3  to generator; equals the latched `MODE` during a run.
- `GEN_TURN`  out  4  to generator; turn code of the current element.
- `DATA_EN`  out  1  to generator; one-cycle registered pulse at each element start.
- `EXP_DATA`  in  DATA_W  from generator compare output.
- `ADDR`  out  ADDR_W  SRAM address.
- `CS`  out  1  SRAM chip select; high for each read or write cycle.
- `WE`  out  1  SRAM write enable. When `CS`=1: `WE`=1 writes, `WE`=0 reads. SRAM write data comes straight from the generator.
- `RDATA`  in  DATA_W  SRAM read data, valid one cycle after a read cycle.
- `BUSY`  out  1  high from the first LOAD through DRAIN.
- `DONE`  out  1  high in DONE state.
- `FAIL`  out  1  sticky mismatch flag for the run.
- `FAIL_ADDR`  out  ADDR_W  first failing address (logging feature).
- `FAIL_CNT`  out  8  saturating mismatch count (logging feature).

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- **IDLE/DONE:** if `START`=1 and `MODE`<=2:
  - latch `MODE`;
  - clear `FAIL`/`FAIL_ADDR`/`FAIL_CNT`;
  - set element index to 0;
  - go to LOAD.
- **IDLE/DONE, unsupported `MODE`:** `START` is ignored and the state is held.
- **LOAD (1 cycle):**
  - drive `GEN_TURN` for the element and pulse `DATA_EN`=1;
  - set `ADDR` to 0 for up/any-direction elements, or N-1 for down elements;
  - `CS`=0.
- **RUN:** sweep all N addresses.
  - Single-op elements: 1 cycle per address.
  - Read-then-write elements: read cycle, then write cycle at the same address (2 cycles per address).
- **Element tables** (turn: op, direction):
  - MSCAN: 1 w up; 1 r up; 3 w up; 3 r up.
  - Checkerboard: 0 w up; 0 r up; F w up; F r up.
  - March C-: 0 w up; 1 r,w up; 2 r,w up; 3 r,w down; 4 r,w down; 5 r up.
- **End of element:** after the last address, go to the next element's LOAD. After the last element, go to DRAIN (1 cycle), then DONE.
- **Compare pipeline:**
  - On every read cycle, register `EXP_DATA` and `ADDR` with a valid bit.
  - Next cycle, compare `RDATA` against the registered expected value. Mismatch sets `FAIL`.
  - Because expected data is captured at read issue, a `DATA_EN` in the following LOAD does not corrupt the compare.
- `DONE` holds until the next accepted `START` or `RESET`.

## Timing
- `RESET`=1 sets state IDLE immediately. All outputs go to 0: `PAT_SEL`, `GEN_TURN`, `DATA_EN`, `ADDR`, `CS`, `WE`, `BUSY`, `DONE`, `FAIL`, `FAIL_ADDR`, `FAIL_CNT`.
- Reset mid-run aborts with no DONE. The pipeline valid bit is cleared.
- `START` accepted at edge k puts LOAD in cycle k+1.
- `BUSY` cycle counts with N=16:
  - MSCAN and checkerboard: 4×(1+16)+1 = 69 cycles.
  - March C-: 17 + 4×33 + 17 + 1 = 167 cycles.
- `DONE` rises the cycle after DRAIN. `FAIL` is final when `DONE` rises.
- Address wrap: the counter stops at N-1 (up) or 0 (down). It never wraps into a second sweep.
- `START` held high through DONE immediately restarts on the next edge.
- `FAIL_CNT` saturates at 255.

## Configuration
- `MBIST_FAIL_LOG_EN` defined:
  - `FAIL_ADDR` captures the address of the first mismatch in the run;
  - `FAIL_CNT` counts all mismatches, saturating.
- Not defined: both ports are present but tied to 0. `FAIL` behaviour is unchanged.

## Structure
- Package `mbist_pkg` holds:
  - pattern codes (MSCAN=0, CHKB=1, MARCHC=2);
  - FSM state enum;
  - element descriptor typedef (turn, op = W/R/RW, dir = UP/DOWN, last flag);
  - element counts per pattern.
- Sub-module `mbist_elem_table`: combinational lookup from (pattern, element index) to element descriptor.

## Test plan
- `MODE`=0 with a fault-free SRAM model, N=16 → 69 `BUSY` cycles, 4 `DATA_EN` pulses with `GEN_TURN` 1,1,3,3, `DONE`=1, `FAIL`=0.
- `MODE`=2, fault-free → 167 `BUSY` cycles, `GEN_TURN` 0..5, elements 3 and 4 sweep `ADDR` 15→0, `FAIL`=0.
- `MODE`=2 with bit 0 of address 5 stuck-at-1 → `FAIL`=1; with `MBIST_FAIL_LOG_EN`, `FAIL_ADDR`=5 and `FAIL_CNT`=3 (failing reads: elements 1, 3, 5).
- `MODE`=1 with address 15 stuck at 8'h55 → mismatch on the final read of element 3, caught in DRAIN; `FAIL`=1, `FAIL_ADDR`=15.
- `RESET` pulsed at cycle 40 of a March C- run → all outputs 0 and state IDLE. A new `START` with `MODE`=0 completes in 69 cycles.
- `START` with `MODE`=5 → no `BUSY`, no `DATA_EN`, `DONE` stays 0.
